// File: rtl/lsu_bus_bridge_pkg.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge_pkg
// Shared definitions for the LSU-to-data-bus bridge: datapath width, LSU access
// size encodings (func3[1:0]) and the bridge state encoding.
// -----------------------------------------------------------------------------
package lsu_bus_bridge_pkg;

    // Datapath and address width of the RV64 core.
    localparam int CPU_WIDTH = 64;
    // Number of byte lanes on the data bus.
    localparam int STRB_W    = CPU_WIDTH / 8;

    // Access size, identical to func3[1:0] of the load/store instruction.
    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } lsu_size_e;

    // Bridge transaction state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } bridge_state_e;

endpackage

// File: rtl/lsu_bus_bridge_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the bridge.
//   Write side (request as presented by the LSU):
//     wr_size, wr_offset, wr_data  -> wr_data_aligned, wr_strb, wr_misaligned
//   Read side (registered request attributes + raw bus doubleword):
//     rd_size, rd_offset, rd_bus_data -> rd_data (right-aligned, size-masked)
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_bus_bridge_pkg::*;
(
    input  logic [1:0]           wr_size,
    input  logic [2:0]           wr_offset,
    input  logic [CPU_WIDTH-1:0] wr_data,
    output logic [CPU_WIDTH-1:0] wr_data_aligned,
    output logic [STRB_W-1:0]    wr_strb,
    output logic                 wr_misaligned,
    input  logic [1:0]           rd_size,
    input  logic [2:0]           rd_offset,
    input  logic [CPU_WIDTH-1:0] rd_bus_data,
    output logic [CPU_WIDTH-1:0] rd_data
);

    // Byte-enable pattern for an access of the given size, starting at lane 0.
    function automatic logic [STRB_W-1:0] size_mask(input logic [1:0] size);
        logic [STRB_W-1:0] mask;
        case (size)
            SIZE_B:  mask = 8'h01;
            SIZE_H:  mask = 8'h03;
            SIZE_W:  mask = 8'h0F;
            SIZE_D:  mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    logic [STRB_W-1:0]    rd_mask_s;
    logic [CPU_WIDTH-1:0] rd_shift_s;

    // Write steering: shift store data and its lane mask up to the byte offset.
    always_comb begin
        wr_data_aligned = wr_data << {wr_offset, 3'b000};
        wr_strb         = size_mask(wr_size) << wr_offset;
    end

    // Misalignment: the low log2(size) address bits must be zero.
    always_comb begin
        case (wr_size)
            SIZE_B:  wr_misaligned = 1'b0;
            SIZE_H:  wr_misaligned = wr_offset[0];
            SIZE_W:  wr_misaligned = |wr_offset[1:0];
            SIZE_D:  wr_misaligned = |wr_offset;
            default: wr_misaligned = 1'b1;
        endcase
    end

    // Read steering: bring the addressed bytes down to lane 0, clear the rest.
    always_comb begin
        rd_mask_s  = size_mask(rd_size);
        rd_shift_s = rd_bus_data >> {rd_offset, 3'b000};
        rd_data    = '0;
        for (int i = 0; i < STRB_W; i++) begin
            if (rd_mask_s[i]) begin
                rd_data[8*i +: 8] = rd_shift_s[8*i +: 8];
            end else begin
                rd_data[8*i +: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// lsu_bus_bridge
// Turns one LSU access into a single transaction on the 64-bit SRAM-style bus,
// with byte-lane alignment, misalignment detection, bus-error forwarding and a
// REQ+WAIT timeout.
//   LSU side : i_req_valid/o_req_ready, i_req_wen, i_req_addr, i_req_wdata,
//              i_req_size; o_rsp_valid/i_rsp_ready, o_rsp_rdata, o_rsp_err
//   Bus side : o_bus_req/i_bus_gnt, o_bus_we, o_bus_addr, o_bus_wdata,
//              o_bus_wstrb; i_bus_rvalid, i_bus_rdata, i_bus_err
//   i_clk rising edge, i_rst synchronous active-high.
// -----------------------------------------------------------------------------
module lsu_bus_bridge
    import lsu_bus_bridge_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req_valid,
    output logic                 o_req_ready,
    input  logic                 i_req_wen,
    input  logic [CPU_WIDTH-1:0] i_req_addr,
    input  logic [CPU_WIDTH-1:0] i_req_wdata,
    input  logic [1:0]           i_req_size,
    output logic                 o_rsp_valid,
    input  logic                 i_rsp_ready,
    output logic [CPU_WIDTH-1:0] o_rsp_rdata,
    output logic                 o_rsp_err,
    output logic                 o_bus_req,
    input  logic                 i_bus_gnt,
    output logic                 o_bus_we,
    output logic [CPU_WIDTH-1:0] o_bus_addr,
    output logic [CPU_WIDTH-1:0] o_bus_wdata,
    output logic [STRB_W-1:0]    o_bus_wstrb,
    input  logic                 i_bus_rvalid,
    input  logic [CPU_WIDTH-1:0] i_bus_rdata,
    input  logic                 i_bus_err
);

    bridge_state_e        state_r, state_nx_s;
    logic [CNT_W-1:0]     cnt_r;
    logic                 we_r;
    logic [CPU_WIDTH-1:0] addr_r;
    logic [CPU_WIDTH-1:0] wdata_r;
    logic [STRB_W-1:0]    wstrb_r;
    logic [1:0]           size_r;
    logic [2:0]           offset_r;
    logic [CPU_WIDTH-1:0] rdata_r;
    logic                 err_r;

    logic                 accept_s;
    logic                 timeout_s;
    logic                 misaligned_s;
    logic [CPU_WIDTH-1:0] wdata_aligned_s;
    logic [STRB_W-1:0]    wstrb_s;
    logic [CPU_WIDTH-1:0] rd_aligned_s;

    lsu_lane_align u_lane_align (
        .wr_size         (i_req_size),
        .wr_offset       (i_req_addr[2:0]),
        .wr_data         (i_req_wdata),
        .wr_data_aligned (wdata_aligned_s),
        .wr_strb         (wstrb_s),
        .wr_misaligned   (misaligned_s),
        .rd_size         (size_r),
        .rd_offset       (offset_r),
        .rd_bus_data     (i_bus_rdata),
        .rd_data         (rd_aligned_s)
    );

    // Request handshake and timeout detection; the counter holds the number
    // of REQ/WAIT cycles already spent, so TIMEOUT-1 marks the last one.
    always_comb begin
        accept_s  = i_req_valid && (state_r == IDLE);
        timeout_s = (cnt_r == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic. Timeout beats a grant in REQ, completion beats timeout
    // in WAIT; rvalid is only looked at in WAIT.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_req_valid) begin
                    state_nx_s = misaligned_s ? RESP : REQ;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            REQ: begin
                if (timeout_s) begin
                    state_nx_s = RESP;
                end else if (i_bus_gnt) begin
                    state_nx_s = WAIT;
                end else begin
                    state_nx_s = REQ;
                end
            end
            WAIT: begin
                if (i_bus_rvalid || timeout_s) begin
                    state_nx_s = RESP;
                end else begin
                    state_nx_s = WAIT;
                end
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = RESP;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Request capture, timeout counter and response data/error registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r    <= '0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            wstrb_r  <= 8'h00;
            size_r   <= 2'd0;
            offset_r <= 3'd0;
            rdata_r  <= '0;
            err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        cnt_r    <= '0;
                        we_r     <= i_req_wen;
                        addr_r   <= {i_req_addr[CPU_WIDTH-1:3], 3'b000};
                        wdata_r  <= wdata_aligned_s;
                        wstrb_r  <= i_req_wen ? wstrb_s : 8'h00;
                        size_r   <= i_req_size;
                        offset_r <= i_req_addr[2:0];
                        rdata_r  <= '0;
                        err_r    <= misaligned_s;
                    end
                end
                REQ: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (i_bus_rvalid) begin
                        err_r   <= i_bus_err;
                        rdata_r <= (!we_r && !i_bus_err) ? rd_aligned_s : '0;
                    end else if (timeout_s) begin
                        err_r <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: every output comes straight from a register.
    always_comb begin
        o_req_ready = (state_r == IDLE);
        o_rsp_valid = (state_r == RESP);
        o_rsp_rdata = rdata_r;
        o_rsp_err   = err_r;
        o_bus_req   = (state_r == REQ);
        o_bus_we    = we_r;
        o_bus_addr  = addr_r;
        o_bus_wdata = wdata_r;
        o_bus_wstrb = wstrb_r;
    end

endmodule

// File: tb/tb_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_lsu_bus_bridge
// Self-checking bench: directed cases plus randomized accesses, each checked
// against a transaction-level reference model (byte loops and plain latency
// arithmetic from the grant/rvalid delays chosen for the bus responder).
// -----------------------------------------------------------------------------
module tb_lsu_bus_bridge;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [63:0] rsp_rdata;
    logic        bus_req, bus_gnt, bus_we, bus_rvalid, bus_err;
    logic [63:0] bus_addr, bus_wdata, bus_rdata;
    logic [7:0]  bus_wstrb;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    lsu_bus_bridge #(.TIMEOUT(TMO), .CNT_W(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_wen    (req_wen),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_size   (req_size),
        .o_rsp_valid  (rsp_valid),
        .i_rsp_ready  (rsp_ready),
        .o_rsp_rdata  (rsp_rdata),
        .o_rsp_err    (rsp_err),
        .o_bus_req    (bus_req),
        .i_bus_gnt    (bus_gnt),
        .o_bus_we     (bus_we),
        .o_bus_addr   (bus_addr),
        .o_bus_wdata  (bus_wdata),
        .o_bus_wstrb  (bus_wstrb),
        .i_bus_rvalid (bus_rvalid),
        .i_bus_rdata  (bus_rdata),
        .i_bus_err    (bus_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One LSU access. gd: REQ cycles without grant before the grant; rd: WAIT
    // cycles before rvalid; hold: cycles the response is back-pressured.
    task automatic do_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [1:0] size, input int gd, input int rd, input int hold,
                          input logic [63:0] rdata_in, input logic err_in, input logic stray);
        int          nb, off, exp_cyc, exp_reqs, reqcnt, waitcnt, cyc;
        logic        mis, timed, exp_err, granted, done;
        logic [63:0] exp_addr, exp_wd, exp_rd;
        logic [7:0]  exp_strb;

        nb       = 1 << size;
        off      = int'(addr[2:0]);
        mis      = (off % nb) != 0;
        timed    = !mis && (gd + rd + 2 > TMO);
        exp_cyc  = mis ? 1 : (timed ? TMO + 1 : gd + rd + 3);
        exp_reqs = mis ? 0 : ((gd + 1 < TMO) ? gd + 1 : TMO);
        exp_err  = mis || timed || err_in;
        exp_addr = addr & ~64'h7;
        exp_wd   = wdata << (8 * off);
        exp_strb = 8'h00;
        exp_rd   = 64'h0;
        for (int b = 0; b < nb; b++) begin
            if (off + b < 8) begin
                exp_strb[off + b] = 1'b1;
                if (!exp_err && !we) exp_rd[8*b +: 8] = rdata_in[8*(off + b) +: 8];
            end
        end

        req_valid = 1'b1;
        req_wen   = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_size  = size;
        check("req_ready_idle", 64'(req_ready), 64'h1);
        tick();
        req_valid = 1'b0;
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};

        reqcnt  = 0;
        waitcnt = 0;
        granted = 1'b0;
        done    = 1'b0;
        cyc     = 1;
        while (cyc <= 40 && !done) begin
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            bus_rdata  = {$urandom, $urandom};
            if (rsp_valid) begin
                done = 1'b1;
            end else begin
                if (bus_req) begin
                    if (reqcnt == 0) begin
                        check("bus_addr", bus_addr, exp_addr);
                        check("bus_we", 64'(bus_we), 64'(we));
                        check("bus_wstrb", 64'(bus_wstrb), we ? 64'(exp_strb) : 64'h0);
                        if (we) check("bus_wdata", bus_wdata, exp_wd);
                    end
                    if (reqcnt == gd) begin
                        bus_gnt = 1'b1;
                        granted = 1'b1;
                        if (stray) begin
                            bus_rvalid = 1'b1;
                            bus_err    = 1'b1;
                        end
                    end
                    reqcnt++;
                end else if (granted) begin
                    if (waitcnt == rd) begin
                        bus_rvalid = 1'b1;
                        bus_rdata  = rdata_in;
                        bus_err    = err_in;
                    end
                    waitcnt++;
                end
                tick();
                cyc++;
            end
        end
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;

        check("rsp_latency", 64'(cyc), 64'(exp_cyc));
        check("bus_req_cycles", 64'(reqcnt), 64'(exp_reqs));
        if (done) begin
            for (int h = 0; h <= hold; h++) begin
                check("rsp_valid", 64'(rsp_valid), 64'h1);
                check("rsp_err", 64'(rsp_err), 64'(exp_err));
                check("rsp_rdata", rsp_rdata, exp_rd);
                if (h < hold) tick();
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            check("bubble_rsp_valid", 64'(rsp_valid), 64'h0);
            check("bubble_req_ready", 64'(req_ready), 64'h1);
        end
    endtask

    initial begin
        int          gd, rd;
        logic [1:0]  sz;
        logic [63:0] a;

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_wen    = 1'b0;
        req_addr   = 64'h0;
        req_wdata  = 64'h0;
        req_size   = 2'd0;
        rsp_ready  = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        bus_rdata  = 64'h0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'h1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("rst_rsp_err", 64'(rsp_err), 64'h0);
        check("rst_rsp_rdata", rsp_rdata, 64'h0);
        check("rst_bus_req", 64'(bus_req), 64'h0);
        check("rst_bus_we", 64'(bus_we), 64'h0);
        check("rst_bus_addr", bus_addr, 64'h0);
        check("rst_bus_wdata", bus_wdata, 64'h0);
        check("rst_bus_wstrb", 64'(bus_wstrb), 64'h0);

        // Directed cases.
        do_txn(1'b1, 64'h8000_0010, 64'h1122_3344_5566_7788, 2'd3, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        do_txn(1'b1, 64'h8000_0005, 64'h0000_0000_0000_00AB, 2'd0, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        do_txn(1'b0, 64'h8000_0006, 64'h0, 2'd1, 0, 0, 0, 64'hBEEF_0000_0000_0000, 1'b0, 1'b0);
        do_txn(1'b0, 64'h8000_0002, 64'h0, 2'd2, 0, 0, 0, 64'h0, 1'b0, 1'b0);
        do_txn(1'b0, 64'h8000_0040, 64'h0, 2'd3, 3, 20, 0, 64'h0, 1'b0, 1'b0);
        do_txn(1'b0, 64'h8000_0048, 64'h0, 2'd3, 1, 3, 0, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        do_txn(1'b0, 64'h8000_0024, 64'h0, 2'd2, 0, 1, 5, 64'hCAFE_F00D_0BAD_BEEF, 1'b0, 1'b1);
        do_txn(1'b0, 64'h8000_0008, 64'h0, 2'd3, 6, 0, 0, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);

        // Reset while waiting for completion, then a stray late rvalid.
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = 64'h8000_0100;
        req_size  = 2'd3;
        tick();
        req_valid = 1'b0;
        bus_gnt   = 1'b1;
        tick();
        bus_gnt = 1'b0;
        check("wait_bus_req_low", 64'(bus_req), 64'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_req_ready", 64'(req_ready), 64'h1);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'h0);
        check("midrst_bus_req", 64'(bus_req), 64'h0);
        bus_rvalid = 1'b1;
        bus_err    = 1'b1;
        bus_rdata  = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        bus_rvalid = 1'b0;
        bus_err    = 1'b0;
        check("stray_rsp_valid", 64'(rsp_valid), 64'h0);
        check("stray_req_ready", 64'(req_ready), 64'h1);
        check("stray_rsp_err", 64'(rsp_err), 64'h0);

        // Randomized accesses.
        for (int t = 0; t < 150; t++) begin
            sz = 2'($urandom_range(0, 3));
            a  = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) a = a & ~((64'h1 << sz) - 64'h1);
            if ($urandom_range(0, 7) == 0) begin
                gd = $urandom_range(0, 8);
                rd = $urandom_range(0, 8);
            end else begin
                gd = $urandom_range(0, 3);
                rd = $urandom_range(0, 3);
            end
            do_txn(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, sz, gd, rd,
                   $urandom_range(0, 2), {$urandom, $urandom},
                   $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Sits directly downstream of the load/store unit. Converts one LSU access per transaction into a single transaction on the 64-bit SRAM-style data bus.
- Performs byte-lane alignment for both directions: write shift plus strobe generation, and read right-shift.
- Flags misaligned accesses and bus errors, and enforces a bus timeout.
- Returns raw right-aligned load data to the LSU, which performs sign or zero extension.

Parameters:
- CPU_WIDTH, 64, datapath and address width; fixed at 64 for the RV64 core.
- TIMEOUT, 255, maximum cycles spent in REQ+WAIT before the access is aborted with an error; must be ≥1.
- CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- i_clk  in  1  core clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_req_valid  in  1  LSU access request.
- o_req_ready  out  1  bridge can accept a request; high only in IDLE.
- i_req_wen  in  1  1 = store, 0 = load.
- i_req_addr  in  CPU_WIDTH  byte address.
- i_req_wdata  in  CPU_WIDTH  store data, right-aligned (byte 0 in bits 7:0).
- i_req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double; equals func3[1:0].
- o_rsp_valid  out  1  response available.
- i_rsp_ready  in  1  LSU accepts the response.
- o_rsp_rdata  out  CPU_WIDTH  load data, right-aligned; 0 for stores and errors.
- o_rsp_err  out  1  misaligned access, bus error, or timeout.
- o_bus_req  out  1  bus request; held until granted.
- i_bus_gnt  in  1  bus accepts the request this cycle.
- o_bus_we  out  1  bus write enable.
- o_bus_addr  out  CPU_WIDTH  request address with bits [2:0] forced to 0.
- o_bus_wdata  out  CPU_WIDTH  write data shifted left by addr[2:0]*8.
- o_bus_wstrb  out  8  byte strobes: size mask shifted left by addr[2:0]; 0 for loads.
- i_bus_rvalid  in  1  completion; one pulse per transaction, for both reads and writes.
- i_bus_rdata  in  CPU_WIDTH  read data for the full aligned doubleword.
- i_bus_err  in  1  bus error, qualified by i_bus_rvalid.

Behaviour:
- Reset: state = IDLE, timeout counter = 0. Outputs after reset: o_req_ready = 1, o_rsp_valid = 0, o_rsp_err = 0, o_rsp_rdata = 0, o_bus_req = 0, o_bus_we = 0, o_bus_addr = 0, o_bus_wdata = 0, o_bus_wstrb = 0.
- Reset mid-transaction forces IDLE immediately. A late i_bus_rvalid for the abandoned transaction, arriving while IDLE, is ignored.
- Request capture: on i_req_valid && o_req_ready, the bridge registers we, addr, aligned wdata, wstrb, size, and offset = addr[2:0].
- Size masks: 8'h01, 8'h03, 8'h0F, 8'hFF for sizes 0 to 3.
- Misaligned access: addr is not a multiple of 2^size.
  - The bridge goes IDLE -> RESP with err = 1 and rdata = 0.
  - No bus activity occurs.
- Aligned access: IDLE -> REQ. Byte-lane crossing of the doubleword cannot occur for an aligned access.
- REQ:
  - o_bus_req = 1, with addr/we/wdata/wstrb stable from registers.
  - On i_bus_gnt -> WAIT.
- WAIT:
  - o_bus_req = 0.
  - On i_bus_rvalid -> RESP. err = i_bus_err.
  - For loads without error: rdata = (i_bus_rdata >> offset*8), masked to size bytes.
  - For stores: rdata = 0.
  - i_bus_rvalid is only sampled in WAIT; a pulse in the same cycle as i_bus_gnt, in REQ, is ignored.
- Timeout:
  - The counter clears on entry to REQ and increments in every REQ or WAIT cycle.
  - When the counter reaches TIMEOUT without completion -> RESP with err = 1 and rdata = 0.
  - o_bus_req is dropped on the transition.
- RESP:
  - o_rsp_valid = 1, with rdata and err held stable.
  - On i_rsp_ready -> IDLE.
  - A new request is not accepted in the same cycle; there is one bubble.
- Minimum latency, with the accept cycle as cycle 0:
  - Bus request in cycle 1.
  - Grant in cycle 1 leads to WAIT in cycle 2.
  - rvalid in cycle 2 leads to o_rsp_valid in cycle 3.
  - Misaligned access: o_rsp_valid in cycle 1.
- At most one outstanding transaction. Throughput is one access per ≥4 cycles.

Decomposition:
- Shared package (core defines): CPU_WIDTH, the size encodings, and the bridge state enum {IDLE, REQ, WAIT, RESP}.
- One sub-module, lsu_lane_align (combinational), contains:
  - size mask generation,
  - write data and strobe shift,
  - read right-shift and mask,
  - the misalignment check.
- The FSM, counter and registers remain in lsu_bus_bridge.

Test Plan:
- Aligned SD: addr = 0x8000_0010, wdata = 0x1122334455667788, size = 3, gnt immediate, rvalid next cycle -> o_bus_addr = 0x8000_0010, wstrb = 8'hFF, wdata unchanged; o_rsp_valid in cycle 3, err = 0.
- Byte store: SB to addr = 0x8000_0005, wdata = 0xAB -> o_bus_addr = 0x8000_0000, wstrb = 8'h20, o_bus_wdata[47:40] = 0xAB.
- Half load: LH from 0x8000_0006, bus rdata = 0xBEEF_0000_0000_0000 -> o_rsp_rdata = 0x0000_0000_0000_BEEF, err = 0.
- Misaligned word load: size = 2, addr = 0x8000_0002 -> no o_bus_req ever asserted; o_rsp_valid = 1 in cycle 1 with err = 1, rdata = 0.
- Stall and timeout: gnt held low 3 cycles, then rvalid withheld, with TIMEOUT = 8 -> o_bus_req held 4 cycles; err response after 8 REQ+WAIT cycles. Separately, a late rvalid with i_bus_err = 1 -> err = 1.
- Backpressure and reset: i_rsp_ready low 5 cycles -> rsp outputs stable. i_rst asserted in WAIT -> next cycle IDLE, o_req_ready = 1, a stray rvalid is ignored, and o_rsp_valid stays 0.
